// File: rtl/exec_ctrl.sv
// Sequencer for a two-byte-instruction core: fetch, execute, memory, halt, error.
// Latency: strobes are Mealy (same cycle as the qualifying input); STATE/HALTED/ERR/ICOUNT follow one edge later.
// Backpressure: MEM_REQ holds until MEM_RDY; a wait of more than MEM_TIMEOUT cycles traps into a sticky ERROR.
module exec_ctrl #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd15,
    parameter int         CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             EN_L,
    input  logic             HLT,
    input  logic             LD,
    input  logic             MD,
    input  logic             MW,
    input  logic             MEM_RDY,
    output logic             PC_EN,
    output logic             IR_LD,
    output logic             RF_WE,
    output logic             MEM_REQ,
    output logic             MEM_WE,
    output logic             HALTED,
    output logic             ERR,
    output logic [2:0]       STATE,
    output logic [CNT_W-1:0] ICOUNT
);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        HALT  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [7:0]       tmo_q;
    logic [CNT_W-1:0] icount_q;
    logic             halted_q;
    logic             err_q;
    logic             en_l_q;

    logic             en_fall;
    logic             tmo_hit;
    logic             waiting;
    logic             retire;
    logic             pc_en_c;
    logic             ir_ld_c;
    logic             rf_we_c;
    logic             mem_req_c;
    logic             mem_we_c;

    // Resume button edge: previous sample high, current sample low.
    assign en_fall = en_l_q & ~EN_L;
    // The limit cycle itself still accepts MEM_RDY; only a miss there traps.
    assign tmo_hit = (tmo_q == MEM_TIMEOUT);

    // Next-state and Mealy strobe decode; ERROR and illegal codes leave every strobe low.
    always_comb begin
        state_nxt = state_q;
        pc_en_c   = 1'b0;
        ir_ld_c   = 1'b0;
        rf_we_c   = 1'b0;
        mem_req_c = 1'b0;
        mem_we_c  = 1'b0;
        retire    = 1'b0;
        waiting   = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req_c = 1'b1;
                if (MEM_RDY) begin
                    ir_ld_c   = 1'b1;
                    state_nxt = EXEC;
                end else begin
                    waiting = 1'b1;
                    if (tmo_hit) state_nxt = ERROR;
                end
            end
            EXEC: begin
                // Halt outranks any memory op decoded alongside it.
                if (HLT) begin
                    state_nxt = HALT;
                end else if (MD || MW) begin
                    state_nxt = MEM;
                end else begin
                    rf_we_c   = LD;
                    pc_en_c   = 1'b1;
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            MEM: begin
                // MD and MW together behave as a store: write to memory, never to the register file.
                mem_req_c = 1'b1;
                mem_we_c  = MW;
                if (MEM_RDY) begin
                    pc_en_c   = 1'b1;
                    rf_we_c   = LD & MD & ~MW;
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end else begin
                    waiting = 1'b1;
                    if (tmo_hit) state_nxt = ERROR;
                end
            end
            HALT: begin
                if (en_fall) begin
                    pc_en_c   = 1'b1;
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt = ERROR;
            end
        endcase
    end

    // State, status flags and button history; reset lands in FETCH with history high.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q  <= FETCH;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            en_l_q   <= 1'b1;
        end else begin
            state_q  <= state_nxt;
            halted_q <= (state_nxt == HALT);
            err_q    <= (state_nxt == ERROR);
            en_l_q   <= EN_L;
        end
    end

    // Wait counter: restarts on every state change, counts cycles spent without MEM_RDY.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            tmo_q <= 8'd0;
        end else if (state_nxt != state_q) begin
            tmo_q <= 8'd0;
        end else if (waiting) begin
            tmo_q <= tmo_q + 8'd1;
        end
    end

    // Retired-instruction counter; wraps silently.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            icount_q <= '0;
        end else if (retire) begin
            icount_q <= icount_q + CNT_W'(1);
        end
    end

    // Reset masks the strobes immediately, even while the state register already reads FETCH.
    assign PC_EN   = pc_en_c   & RESET_L;
    assign IR_LD   = ir_ld_c   & RESET_L;
    assign RF_WE   = rf_we_c   & RESET_L;
    assign MEM_REQ = mem_req_c & RESET_L;
    assign MEM_WE  = mem_we_c  & RESET_L;
    assign HALTED  = halted_q;
    assign ERR     = err_q;
    assign STATE   = state_q;
    assign ICOUNT  = icount_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: instruction flows, halt/resume, timeout trap, counter wrap, reset.
// Latency: inputs change on the falling edge, outputs sampled 1 ns later.
// Backpressure: MEM_RDY is driven per cycle from the vector lists below.
module tb_exec_ctrl;

    localparam int TB_CNT_W = 8;

    logic                CLK;
    logic                RESET_L;
    logic                EN_L;
    logic                HLT;
    logic                LD;
    logic                MD;
    logic                MW;
    logic                MEM_RDY;
    logic                PC_EN;
    logic                IR_LD;
    logic                RF_WE;
    logic                MEM_REQ;
    logic                MEM_WE;
    logic                HALTED;
    logic                ERR;
    logic [2:0]          STATE;
    logic [TB_CNT_W-1:0] ICOUNT;
    logic [4:0]          strb;

    int n_vec = 0;
    int n_bad = 0;

    // Strobe vector bit order: PC_EN IR_LD RF_WE MEM_REQ MEM_WE
    localparam logic [4:0] S_NONE  = 5'b00000;
    localparam logic [4:0] S_REQ   = 5'b00010;
    localparam logic [4:0] S_FETCH = 5'b01010;
    localparam logic [4:0] S_ALU   = 5'b10100;
    localparam logic [4:0] S_PC    = 5'b10000;
    localparam logic [4:0] S_LDONE = 5'b10110;
    localparam logic [4:0] S_SDONE = 5'b10011;

    exec_ctrl #(.MEM_TIMEOUT(8'd15), .CNT_W(TB_CNT_W)) dut (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .EN_L    (EN_L),
        .HLT     (HLT),
        .LD      (LD),
        .MD      (MD),
        .MW      (MW),
        .MEM_RDY (MEM_RDY),
        .PC_EN   (PC_EN),
        .IR_LD   (IR_LD),
        .RF_WE   (RF_WE),
        .MEM_REQ (MEM_REQ),
        .MEM_WE  (MEM_WE),
        .HALTED  (HALTED),
        .ERR     (ERR),
        .STATE   (STATE),
        .ICOUNT  (ICOUNT)
    );

    assign strb = {PC_EN, IR_LD, RF_WE, MEM_REQ, MEM_WE};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cs(input string tag, input logic [4:0] es, input logic [2:0] est);
        chk({tag, "_strb"}, 32'(strb), 32'(es));
        chk({tag, "_state"}, 32'(STATE), 32'(est));
    endtask

    // One cycle: drive at the falling edge, settle, then the caller samples.
    task automatic step(input logic rdy, input logic hlt, input logic ld,
                        input logic md, input logic mw, input logic en_l);
        @(negedge CLK);
        MEM_RDY = rdy;
        HLT     = hlt;
        LD      = ld;
        MD      = md;
        MW      = mw;
        EN_L    = en_l;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_L = 1'b1;
        EN_L = 1'b1; HLT = 1'b0; LD = 1'b0; MD = 1'b0; MW = 1'b0; MEM_RDY = 1'b0;
        #2 RESET_L = 1'b0;
        #1;
        cs("rst", S_NONE, 3'd0);
        chk("rst_icount", 32'(ICOUNT), 32'd0);
        chk("rst_halted", 32'(HALTED), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        @(negedge CLK);
        RESET_L = 1'b1;

        // ALU instruction with register write
        step(1, 0, 1, 0, 0, 1); cs("alu_fetch", S_FETCH, 3'd0);
        step(0, 0, 1, 0, 0, 1); cs("alu_exec", S_ALU, 3'd1);

        // Load with MEM_RDY three cycles late
        step(1, 0, 1, 1, 0, 1); cs("ld_fetch", S_FETCH, 3'd0);
        chk("alu_icount", 32'(ICOUNT), 32'd1);
        step(0, 0, 1, 1, 0, 1); cs("ld_exec", S_NONE, 3'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 0, 1); cs("ld_wait", S_REQ, 3'd2);
        end
        step(1, 0, 1, 1, 0, 1); cs("ld_done", S_LDONE, 3'd2);

        // MD and MW together act as a store
        step(1, 0, 1, 1, 1, 1); cs("st_fetch", S_FETCH, 3'd0);
        chk("ld_icount", 32'(ICOUNT), 32'd2);
        step(0, 0, 1, 1, 1, 1); cs("st_exec", S_NONE, 3'd1);
        step(1, 0, 1, 1, 1, 1); cs("st_done", S_SDONE, 3'd2);

        // Halt overrides memory decode; MEM_RDY ignored while halted
        step(1, 0, 0, 0, 0, 1); cs("h_fetch", S_FETCH, 3'd0);
        chk("st_icount", 32'(ICOUNT), 32'd3);
        step(0, 1, 0, 1, 1, 1); cs("h_exec", S_NONE, 3'd1);
        step(1, 0, 0, 0, 0, 1); cs("h_idle", S_NONE, 3'd3);
        chk("h_halted", 32'(HALTED), 32'd1);
        step(0, 0, 0, 0, 0, 0); cs("h_resume", S_PC, 3'd3);

        // EN_L kept low through a second halt must not resume it
        step(1, 0, 0, 0, 0, 0); cs("r_fetch", S_FETCH, 3'd0);
        chk("r_halted", 32'(HALTED), 32'd0);
        chk("r_icount", 32'(ICOUNT), 32'd4);
        step(0, 1, 0, 0, 0, 0); cs("r_exec", S_NONE, 3'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0); cs("r_hold", S_NONE, 3'd3);
        end
        step(0, 0, 0, 0, 0, 1); cs("r_release", S_NONE, 3'd3);
        step(0, 0, 0, 0, 0, 0); cs("r_press", S_PC, 3'd3);

        // MEM_RDY on the limit cycle is accepted
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 0, 0, 0, 1); cs("tb_wait", S_REQ, 3'd0);
        end
        step(1, 0, 0, 0, 0, 1); cs("tb_limit_rdy", S_FETCH, 3'd0);
        step(0, 0, 0, 0, 0, 1); cs("tb_exec", S_PC, 3'd1);

        // Missing MEM_RDY on the limit cycle traps into ERROR
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0, 0, 1); cs("to_wait", S_REQ, 3'd0);
        end
        step(1, 0, 0, 0, 0, 1); cs("to_err", S_NONE, 3'd4);
        chk("to_err_flag", 32'(ERR), 32'd1);
        chk("to_icount", 32'(ICOUNT), 32'd6);
        step(1, 0, 1, 0, 0, 0); cs("to_sticky", S_NONE, 3'd4);

        // Asynchronous reset clears ERROR without a clock edge
        #1 RESET_L = 1'b0;
        #1;
        cs("rst2", S_NONE, 3'd0);
        chk("rst2_err", 32'(ERR), 32'd0);
        chk("rst2_icount", 32'(ICOUNT), 32'd0);
        @(negedge CLK);
        RESET_L = 1'b1;

        // Counter wrap from all-ones to zero
        for (int i = 0; i < 255; i++) begin
            step(1, 0, 0, 0, 0, 1);
            step(0, 0, 0, 0, 0, 1);
        end
        step(1, 0, 0, 1, 0, 1); cs("w_fetch", S_FETCH, 3'd0);
        chk("w_full", 32'(ICOUNT), 32'hFF);
        step(0, 0, 0, 0, 0, 1); cs("w_exec", S_PC, 3'd1);
        step(1, 0, 0, 1, 0, 1); cs("w2_fetch", S_FETCH, 3'd0);
        chk("w_zero", 32'(ICOUNT), 32'd0);
        chk("w_noerr", 32'(ERR), 32'd0);

        // Reset in the middle of a memory wait
        step(0, 0, 0, 1, 0, 1); cs("m_exec", S_NONE, 3'd1);
        step(0, 0, 0, 1, 0, 1); cs("m_wait", S_REQ, 3'd2);
        #1 RESET_L = 1'b0;
        #1;
        cs("m_rst", S_NONE, 3'd0);
        @(negedge CLK);
        RESET_L = 1'b1;
        step(0, 0, 0, 0, 0, 1); cs("m_restart", S_REQ, 3'd0);
        chk("m_icount", 32'(ICOUNT), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 8'd15, meaning the maximum number of cycles MEM_REQ may wait for MEM_RDY before an error.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the retired-instruction counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RESET_L  input  1  asynchronous active-low reset.
REQ-006 EN_L  input  1  active-low resume button, synchronous to CLK.
REQ-007 HLT  input  1  decoded halt.
REQ-008 LD  input  1  decoded register-write.
REQ-009 MD  input  1  decoded load (DataC from Din).
REQ-010 MW  input  1  decoded store.
REQ-011 MEM_RDY  input  1  memory completion, valid while MEM_REQ=1.
REQ-012 PC_EN  output  1  one-cycle strobe advancing PC by 2.
REQ-013 IR_LD  output  1  one-cycle strobe capturing Iin.
REQ-014 RF_WE  output  1  register-file write strobe.
REQ-015 MEM_REQ  output  1  memory access request.
REQ-016 MEM_WE  output  1  write qualifier for MEM_REQ.
REQ-017 HALTED  output  1  high in HALT.
REQ-018 ERR  output  1  high in ERROR.
REQ-019 STATE  output  3  current state encoding.
REQ-020 ICOUNT  output  CNT_W  retired-instruction count.

Function
REQ-021 SHALL use states FETCH=0, EXEC=1, MEM=2, HALT=3, ERROR=4; codes 5-7 SHALL go to ERROR on the next edge.
REQ-022 FETCH: MEM_REQ=1 and MEM_WE=0; when MEM_RDY=1, IR_LD=1 in that cycle and the next state is EXEC.
REQ-023 EXEC, HLT=1: no strobes; next state is HALT; HLT SHALL override MD and MW.
REQ-024 EXEC, MD=1 or MW=1 (HLT=0): no strobes; next state is MEM.
REQ-025 EXEC, otherwise: RF_WE=LD and PC_EN=1 in that cycle; ICOUNT increments; next state is FETCH.
REQ-026 MEM: MEM_REQ=1 and MEM_WE=MW; when MEM_RDY=1, PC_EN=1, RF_WE=LD&MD&~MW, ICOUNT increments, and the next state is FETCH.
REQ-027 MD=MW=1 SHALL be treated as a store: MEM_WE=1 and RF_WE=0.
REQ-028 Strobe outputs SHALL be combinational from state and inputs (Mealy); STATE, HALTED, ERR and ICOUNT SHALL be registered.
REQ-029 Timeout counter: 8-bit, cleared on entry to FETCH or MEM, increments each waiting cycle.
- Reaching MEM_TIMEOUT with MEM_RDY=0 SHALL enter ERROR on the next edge.
- MEM_RDY in the same cycle as the limit SHALL win.
REQ-030 HALT: HALTED=1. A falling edge of EN_L (previous sample 1, current 0) SHALL produce PC_EN=1 and ICOUNT increment that cycle, then FETCH; EN_L held low SHALL NOT re-trigger.
REQ-031 ERROR: sticky until reset; ERR=1; PC_EN, IR_LD, RF_WE, MEM_REQ and MEM_WE forced 0.
REQ-032 ICOUNT SHALL wrap from all-ones to 0 without flagging.
REQ-033 MEM_RDY outside FETCH/MEM SHALL be ignored.

Reset
REQ-034 RESET_L=0 SHALL immediately, without waiting for a clock edge, set STATE=FETCH, ICOUNT=0, timeout=0, HALTED=0, ERR=0, EN_L history=1, and force all strobes and MEM_REQ to 0.
REQ-035 Reset asserted mid-MEM SHALL drop MEM_REQ combinationally; after release FETCH SHALL restart, with MEM_REQ=1 on the first cycle.

Verification
REQ-036 ALU instruction: MEM_RDY=1 in FETCH, then LD=1 in EXEC -> IR_LD cycle, then PC_EN=RF_WE=1 cycle; ICOUNT=1, STATE back to 0.
REQ-037 Load with MEM_RDY delayed 3 cycles: MD=LD=1 -> MEM_REQ=1, MEM_WE=0 for 4 cycles; RF_WE=PC_EN=1 only on the RDY cycle.
REQ-038 Halt then resume: HLT=1 -> HALTED=1 with no PC_EN; EN_L 1->0 -> one PC_EN; holding EN_L=0 for 5 cycles -> no further PC_EN.
REQ-039 Timeout: MEM_RDY stuck 0 in FETCH -> ERR=1 and STATE=4 after 15 wait cycles; a later MEM_RDY=1 gives no strobes until RESET_L pulses.
REQ-040 Counter wrap and reset: preload via 65535 retirements -> ICOUNT=0 after the next one; RESET_L=0 mid-MEM -> MEM_REQ=0 the same cycle, STATE=0.
